// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: bus widths, stall masks, FSM states.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W   = 32;
  localparam int unsigned STALL_W = 6;

  localparam logic [REG_W-1:0] ZERO_WORD       = '0;
  localparam logic [REG_W-1:0] EXC_VEC_DEFAULT = 32'h0000_0020;

  // Stall masks: bit0=PC .. bit5=WB; WB never holds.
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at LIMIT.
module sat_cnt #(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: per-stage stall mask, one-cycle flush with
// PC redirect, and stall statistics with a sticky long-stall timeout.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned      MAX_STALL = 255,
  parameter logic [REG_W-1:0] EXC_VEC   = EXC_VEC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  input  logic               excp_valid,
  input  logic               excp_eret,
  input  logic [REG_W-1:0]   cp0_epc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [REG_W-1:0]   new_pc,
  output logic [31:0]        stall_cnt,
  output logic               stall_timeout
);

  localparam int unsigned RUN_W = $clog2(MAX_STALL + 1);

  state_e             r_state;
  state_e             w_next;
  logic               r_flush;
  logic [REG_W-1:0]   r_new_pc;
  logic [REG_W-1:0]   w_pc_next;
  logic [STALL_W-1:0] w_stall;
  logic               w_any_req;
  logic               w_stall_any;
  logic [RUN_W-1:0]   w_run_cnt;
  logic               r_timeout;

  assign w_any_req = stallreq_id | stallreq_ex | stallreq_mem;

  // Next state and combinational stall mask; exceptions and FLUSH suppress stalls.
  always_comb begin
    w_next    = r_state;
    w_stall   = STALL_NONE;
    w_pc_next = ZERO_WORD;
    if (excp_valid) begin
      w_next    = ST_FLUSH;
      w_pc_next = excp_eret ? cp0_epc : EXC_VEC;
    end else if (w_any_req) begin
      w_next = ST_STALL;
    end else begin
      w_next = ST_RUN;
    end
    if (rst && !excp_valid && (r_state != ST_FLUSH)) begin
      if (stallreq_mem)     w_stall = STALL_MEM;
      else if (stallreq_ex) w_stall = STALL_EX;
      else if (stallreq_id) w_stall = STALL_ID;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_RUN;
      r_flush  <= 1'b0;
      r_new_pc <= ZERO_WORD;
    end else begin
      r_state  <= w_next;
      r_flush  <= (w_next == ST_FLUSH);
      r_new_pc <= w_pc_next;
    end
  end

  assign w_stall_any = |w_stall;

  sat_cnt #(
    .WIDTH (32),
    .LIMIT (32'hFFFF_FFFF)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_stall_any),
    .i_clr (1'b0),
    .o_cnt (stall_cnt)
  );

  sat_cnt #(
    .WIDTH (RUN_W),
    .LIMIT (RUN_W'(MAX_STALL))
  ) u_run_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_stall_any),
    .i_clr (!w_stall_any),
    .o_cnt (w_run_cnt)
  );

  // Sets on the same edge the run counter reaches MAX_STALL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timeout <= 1'b0;
    end else if (w_stall_any && (w_run_cnt >= RUN_W'(MAX_STALL - 1))) begin
      r_timeout <= 1'b1;
    end
  end

  assign stall         = w_stall;
  assign flush         = r_flush;
  assign new_pc        = r_new_pc;
  assign stall_timeout = r_timeout;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MAX_STALL, default 255: consecutive stall cycles before timeout is flagged.
REQ-002 Parameter EXC_VEC, default 32'h0000_0020: exception entry address.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 stallreq_id  input  1  ID stage stall request (load-use hazard).
REQ-006 stallreq_ex  input  1  EX stage stall request (multi-cycle MADD/DIV).
REQ-007 stallreq_mem  input  1  MEM stage stall request (data bus wait).
REQ-008 excp_valid  input  1  exception or ERET committed in MEM this cycle.
REQ-009 excp_eret  input  1  qualifies excp_valid: 1 = ERET, 0 = exception.
REQ-010 cp0_epc  input  `RegBus  return address for ERET.
REQ-011 stall  output  6  per-stage hold: [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB.
REQ-012 flush  output  1  clear all pipeline registers, including MEM/WB.
REQ-013 new_pc  output  `RegBus  PC redirect target; valid while flush=1.
REQ-014 stall_cnt  output  32  total stall cycles since reset, saturating.
REQ-015 stall_timeout  output  1  sticky: one stall episode reached MAX_STALL.

Function
REQ-016 FSM states SHALL be RUN, STALL and FLUSH, in a single 2-bit state register.
REQ-017 stall SHALL be combinational from the current-cycle requests and the state, so a stalled stage holds in the same cycle the request appears.
REQ-018 In RUN or STALL, stall SHALL be 6'b011111 if stallreq_mem, else 6'b001111 if stallreq_ex, else 6'b000111 if stallreq_id, else 6'b000000.
REQ-019 stall[5] SHALL be 0 always: WB never holds.
REQ-020 excp_valid=1 in RUN or STALL in cycle N SHALL force stall=0 in cycle N and move the FSM to FLUSH for cycle N+1.
REQ-021 In FLUSH, flush=1 SHALL be a registered output for exactly one cycle.
REQ-022 In FLUSH, new_pc SHALL equal cp0_epc sampled in cycle N if excp_eret=1, else EXC_VEC.
REQ-023 Outside FLUSH, flush=0 and new_pc=`ZeroWord.
REQ-024 In FLUSH, stall SHALL be 0 and all stall requests SHALL be ignored.
REQ-025 excp_valid=1 during FLUSH SHALL be accepted: FLUSH repeats for one more cycle with a new_pc recomputed from the new inputs.
REQ-026 From FLUSH, the next state SHALL be FLUSH if excp_valid, else STALL if any stall request, else RUN.
REQ-027 From RUN or STALL without excp_valid, the next state SHALL be STALL if any stall request, else RUN.
REQ-028 Exception SHALL have priority over all stall requests arriving in the same cycle.
REQ-029 stall_cnt SHALL increment by 1 each cycle stall!=0 and saturate at 32'hFFFF_FFFF.
REQ-030 A run counter SHALL count consecutive cycles with stall!=0.
REQ-031 The run counter SHALL clear on any cycle with stall=0 and saturate at MAX_STALL.
REQ-032 stall_timeout SHALL set on the cycle the run counter reaches MAX_STALL, and clear only on reset.

Reset
REQ-033 While rst=0, the following SHALL hold immediately, without waiting for clk: state=RUN, flush=0, new_pc=`ZeroWord, stall_cnt=0, run counter=0, stall_timeout=0.
REQ-034 While rst=0, stall SHALL be 6'b000000 regardless of the requests.
REQ-035 Reset asserted during FLUSH SHALL drop flush in the same cycle, with no residual redirect after release.
REQ-036 The first posedge after rst rises SHALL evaluate inputs normally from RUN.

Structure
REQ-037 The stall encodings, state encodings and EXC_VEC default SHALL live in the shared defines package, alongside `RegBus and `ZeroWord.
REQ-038 The saturating counter SHALL be one sub-module, sat_cnt, parameterised by width and limit, and instantiated twice (stall_cnt and the run counter).

Verification
REQ-039 Reset check: rst=0 with all requests=1 -> stall=0, flush=0, stall_cnt=0; after release, stallreq_mem=1 -> stall=6'b011111 in the same cycle.
REQ-040 Stall priority: stallreq_id=1 and stallreq_ex=1 for 3 cycles -> stall=6'b001111 on each, stall_cnt=3.
REQ-041 Exception vs stall: excp_valid=1, excp_eret=0, stallreq_ex=1 in cycle N -> stall=0 in N; flush=1 and new_pc=32'h20 in N+1 only.
REQ-042 ERET: excp_valid=1, excp_eret=1, cp0_epc=32'hBFC0_0100 -> new_pc=32'hBFC0_0100 with flush=1 for exactly one cycle.
REQ-043 Back-to-back exceptions: excp_valid=1 in N and N+1 -> flush=1 in N+1 and N+2, with stall=0 throughout.
REQ-044 Timeout (MAX_STALL=4): stallreq_id=1 for 4 cycles -> stall_timeout=1 at cycle 4; it stays 1 after the request drops.
